// File: rtl/fft_sdf_pkg.sv
// Shared types and constants for the SDF FFT sequencer.
package fft_sdf_pkg;

  localparam int NS = 6;
  localparam int N  = 1 << NS;
  localparam int LW = NS - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

  // Delay of stage k relative to the sample counter, for an n-point transform.
  function automatic int stage_offset(input int n, input int k);
    return n - (n >> k);
  endfunction

endpackage

// File: rtl/fft_sdf_stage_timer.sv
// Per-stage butterfly/bypass select and twiddle address from the shared sample count.
module sdf_stage_timer #(
  parameter int NS = 6,
  parameter int K  = 0
) (
  input  logic [NS-1-K:0] c,
  output logic            mode,
  output logic [NS-2:0]   tw
);
  import fft_sdf_pkg::*;

  localparam int CW   = NS - K;
  localparam int LOFF = stage_offset(1 << NS, K) % (1 << CW);

  // Only the low NS-K bits of the local count matter for this stage.
  logic [CW-1:0] ck;

  assign ck   = c - CW'(LOFF);
  assign mode = ck[CW-1];

  if (K == NS - 1) begin : g_last
    assign tw = '0;
  end else begin : g_tw
    assign tw = (NS-1)'(ck[CW-2:0]) << K;
  end

endmodule

// File: rtl/fft_sdf_sched.sv
// Sample counter, fill/drain control and per-stage timing for the radix-2 SDF FFT pipeline.
module fft_sdf_sched #(
  parameter int NS = fft_sdf_pkg::NS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               en,
  output logic [NS-1:0]      stage_mode,
  output logic [NS*(NS-1)-1:0] tw_addr,
  output logic               out_valid,
  output logic               out_first,
  output logic               busy,
  output logic               err_frame
);
  import fft_sdf_pkg::*;

  localparam int LW = NS - 1;
  localparam logic [NS-1:0] CMAX = NS'((1 << NS) - 1);
  localparam logic [NS-1:0] DEND = NS'((1 << NS) - 2);

  sched_state_t state, state_nxt;
  logic [NS-1:0] c, f, d;
  logic          accept, drain_done;

  assign accept     = in_ready & in_valid;
  assign drain_done = (state == DRAIN) && (d == DEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DRAIN : RUN;
      RUN:     if (accept && in_last) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    en       = accept;
    busy     = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      DRAIN: begin
        in_ready = 1'b0;
        en       = 1'b1;
      end
      default: ;
    endcase
  end

  // Drain count d runs alongside c/f; all three restart together at end of drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c         <= '0;
      f         <= '0;
      d         <= '0;
      err_frame <= 1'b0;
    end else begin
      if (drain_done) begin
        c <= '0;
        f <= '0;
        d <= '0;
      end else if (en) begin
        c <= c + 1'b1;
        if (f != CMAX) f <= f + 1'b1;
        if (state == DRAIN) d <= d + 1'b1;
      end
      if (accept && in_last && (c != CMAX)) err_frame <= 1'b1;
    end
  end

  assign out_valid = en & (f == CMAX);
  assign out_first = out_valid & (c == CMAX);

  for (genvar k = 0; k < NS; k++) begin : g_stage
    sdf_stage_timer #(.NS(NS), .K(k)) u_timer (
      .c    (c[NS-1-k:0]),
      .mode (stage_mode[k]),
      .tw   (tw_addr[k*LW +: LW])
    );
  end

endmodule

// File: tb/tb_fft_sdf_sched.sv
// Directed checks of the SDF scheduler at N = 8 and N = 64.
module tb_fft_sdf_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_last;
  logic in_ready, en, out_valid, out_first, busy, err_frame;
  logic [2:0] stage_mode;
  logic [5:0] tw_addr;

  logic v6, l6;
  logic rdy6, en6, ov6, of6, busy6, err6;
  logic [5:0]  mode6;
  logic [29:0] tw6;

  fft_sdf_sched #(.NS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .en(en), .stage_mode(stage_mode), .tw_addr(tw_addr),
    .out_valid(out_valid), .out_first(out_first), .busy(busy), .err_frame(err_frame)
  );

  fft_sdf_sched #(.NS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_last(l6),
    .in_ready(rdy6), .en(en6), .stage_mode(mode6), .tw_addr(tw6),
    .out_valid(ov6), .out_first(of6), .busy(busy6), .err_frame(err6)
  );

  int vectors = 0;
  int miscompares = 0;

  // Hand-derived for N = 8: stage_mode is c bit-reversed; tw = {00, c[0],0, c[1:0]}.
  logic [2:0] mode_tbl [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
  logic [5:0] tw_tbl   [8] = '{6'h00, 6'h09, 6'h02, 6'h0B, 6'h00, 6'h09, 6'h02, 6'h0B};
  int         gap_tbl  [8] = '{1, 3, 2, 1, 2, 3, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int i, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    #1;
    chk("run_en", en, 1);
    chk("run_ready", in_ready, 1);
    chk("stage_mode", stage_mode, mode_tbl[i]);
    chk("tw_addr", tw_addr, tw_tbl[i]);
    chk("run_out_valid", out_valid, (i == 7) ? 1 : 0);
    chk("run_out_first", out_first, (i == 7) ? 1 : 0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_full();
    for (int j = 0; j < 7; j++) begin
      in_valid = (j == 2);
      #1;
      chk("drain_busy", busy, 1);
      chk("drain_ready", in_ready, 0);
      chk("drain_en", en, 1);
      chk("drain_out_valid", out_valid, 1);
      chk("drain_out_first", out_first, 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("post_drain_busy", busy, 0);
    chk("post_drain_ready", in_ready, 1);
    chk("post_drain_en", en, 0);
  endtask

  initial begin
    int first_ov, ndrain;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; v6 = 1'b0; l6 = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    chk("rst_ready", in_ready, 1);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_mode", stage_mode, 0);
    chk("rst_tw", tw_addr, 0);
    chk("rst_err", err_frame, 0);

    // Clean back-to-back samples.
    for (int i = 0; i < 8; i++) sample(i, i == 7);
    chk("frame_err", err_frame, 0);
    drain_full();

    // Same frame with stalls; nothing may move while in_valid is low.
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap_tbl[i]; g++) begin
        #1;
        chk("stall_en", en, 0);
        chk("stall_out_valid", out_valid, 0);
        chk("stall_mode", stage_mode, mode_tbl[i]);
        chk("stall_tw", tw_addr, tw_tbl[i]);
        tick();
      end
      sample(i, i == 7);
    end
    drain_full();

    // Short frame: in_last on the 5th sample.
    for (int i = 0; i < 5; i++) sample(i, i == 4);
    #1;
    chk("short_err", err_frame, 1);
    for (int j = 0; j < 7; j++) begin
      chk("short_drain_en", en, 1);
      chk("short_drain_out_valid", out_valid, (j >= 2) ? 1 : 0);
      tick();
    end
    #1;
    chk("short_idle_busy", busy, 0);
    chk("short_err_sticky", err_frame, 1);

    // Reset in the middle of a frame with c = 3.
    for (int i = 0; i < 3; i++) sample(i, 1'b0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_err", err_frame, 0);
    chk("mid_rst_mode", stage_mode, 0);
    chk("mid_rst_tw", tw_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) sample(i, i == 7);
    drain_full();

    // N = 64: first valid bin on the 64th advance, then 63 drain cycles.
    first_ov = -1;
    for (int i = 0; i < 64; i++) begin
      v6 = 1'b1;
      l6 = (i == 63);
      #1;
      if (ov6 && first_ov < 0) begin
        first_ov = i + 1;
        chk("n64_out_first", of6, 1);
      end
      tick();
    end
    v6 = 1'b0; l6 = 1'b0;
    chk("n64_first_valid_en", first_ov, 64);
    ndrain = 0;
    for (int t = 0; t < 100 && busy6; t++) begin
      if (en6) ndrain++;
      tick();
    end
    chk("n64_drain_len", ndrain, 63);
    chk("n64_idle", busy6, 0);
    chk("n64_err", err6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
